load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: bridges core byte/half/word accesses onto a 32-bit
// word bus with lane steering, sign/zero extension and a wait timeout.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [3:0]  i_mem_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic        o_bus_valid,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [31:0]    addr_q, addr_d;
    logic           we_q, we_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           fault_q, fault_d;
    logic [31:0]    rdata_q, rdata_d;

    logic           op_legal;
    logic           op_store;
    logic           misaligned;
    logic [3:0]     be_n;
    logic [31:0]    wdata_n;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_value;
    logic [CW-1:0]  cnt_inc;
    logic           to_hit;

    // Decode the incoming request: legality, alignment, lanes, store data
    always_comb begin
        op_legal   = (i_mem_op[3] == 1'b0);
        op_store   = op_legal && (i_mem_op >= 4'd5);
        misaligned = 1'b0;
        be_n       = 4'b0001 << i_addr[1:0];
        wdata_n    = 32'd0;
        case (i_mem_op)
            4'd1, 4'd4, 4'd6: begin
                misaligned = i_addr[0];
                be_n       = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            4'd2, 4'd7: begin
                misaligned = |i_addr[1:0];
                be_n       = 4'b1111;
            end
            default: ;
        endcase
        case (i_mem_op)
            4'd5:    wdata_n = {4{i_wdata[7:0]}};
            4'd6:    wdata_n = {2{i_wdata[15:0]}};
            4'd7:    wdata_n = i_wdata;
            default: wdata_n = 32'd0;
        endcase
    end

    // Pick the addressed lane from the read word and extend it
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = i_bus_rdata[7:0];
            2'd1:    ld_byte = i_bus_rdata[15:8];
            2'd2:    ld_byte = i_bus_rdata[23:16];
            default: ld_byte = i_bus_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (op_q)
            4'd0:    ld_value = {{24{ld_byte[7]}}, ld_byte};
            4'd1:    ld_value = {{16{ld_half[15]}}, ld_half};
            4'd3:    ld_value = {24'd0, ld_byte};
            4'd4:    ld_value = {16'd0, ld_half};
            default: ld_value = i_bus_rdata;
        endcase
    end

    // Wait counter increment and timeout detection
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        to_hit  = (TIMEOUT != 0) && (cnt_inc == TO_LIM);
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    op_d    = i_mem_op;
                    addr_d  = i_addr;
                    we_d    = op_store;
                    be_d    = be_n;
                    wdata_d = wdata_n;
                    if (!op_legal || misaligned) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        if (!op_store) begin
                            rdata_d = 32'd0;
                        end
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            S_REQ: begin
                if (i_bus_ready) begin
                    if (we_q) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RESP;
                    end
                end else if (to_hit) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                if (i_bus_rvalid) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    rdata_d = ld_value;
                end else if (to_hit) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-request registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_fault     = fault_q;
    assign o_rdata     = rdata_q;
    assign o_bus_valid = (state_q == S_REQ);
    assign o_bus_we    = we_q;
    assign o_bus_addr  = {addr_q[31:2], 2'b00};
    assign o_bus_be    = be_q;
    assign o_bus_wdata = wdata_q;

endmodule
